dsp_mac_fir_seq: RTL and testbench

- Time-multiplexed FIR sequencer that drives one DSP_SLC_LOGIC slice from its input side and closes the accumulation loop through the slice's PCIN/P path.
- Holds the coefficients and the sample delay line, and issues one coefficient/sample pair per cycle for NTAPS cycles.
- Controls USE_PCIN so the slice accumulates across taps, then captures P as the filter output with a strobe.
- Sits between the pixel stream and a single slice, replacing a cascade of NTAPS slices.

---
 rtl/dsp_pkg.sv | 19 +
 rtl/dsp_tap_mem.sv | 42 ++++
 rtl/dsp_mac_fir_seq.sv | 150 +++++++++++++++
 tb/tb_dsp_mac_fir_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared constants and types for sequencers that drive a DSP_SLC_LOGIC slice.
// SLC_TRUNC/SLC_SHIFT describe the slice's own arithmetic; the sequencer never compensates for them.
package dsp_pkg;

    localparam int SLC_LAT   = 4;
    localparam int SLC_TRUNC = 4;
    localparam int SLC_SHIFT = 8;

    typedef struct packed {
        logic tap0;
        logic last;
    } tag_t;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_t;

endpackage

// File: rtl/dsp_tap_mem.sv
// Coefficient register file plus circular sample delay line, one read port each.
// Storage is sized to the full address space so any address indexes safely; writes above NTAPS are dropped.
module dsp_tap_mem #(
    parameter int IN_WIDTH = 18,
    parameter int NTAPS    = 5,
    parameter int ADDR_W   = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_coef_we,
    input  logic [ADDR_W-1:0]   i_coef_addr,
    input  logic [IN_WIDTH-1:0] i_coef_data,
    input  logic                i_x_we,
    input  logic [ADDR_W-1:0]   i_x_addr,
    input  logic [IN_WIDTH-1:0] i_x_data,
    input  logic [ADDR_W-1:0]   i_h_raddr,
    output logic [IN_WIDTH-1:0] o_h_rdata,
    input  logic [ADDR_W-1:0]   i_x_raddr,
    output logic [IN_WIDTH-1:0] o_x_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][IN_WIDTH-1:0] r_h;
    logic [DEPTH-1:0][IN_WIDTH-1:0] r_x;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_x <= '0;
        end else begin
            if (i_coef_we && (int'(i_coef_addr) < NTAPS))
                r_h[i_coef_addr] <= i_coef_data;
            if (i_x_we)
                r_x[i_x_addr] <= i_x_data;
        end
    end

    assign o_h_rdata = r_h[i_h_raddr];
    assign o_x_rdata = r_x[i_x_addr == i_x_raddr && i_x_we ? i_x_raddr : i_x_raddr];

endmodule

// File: rtl/dsp_mac_fir_seq.sv
// Time-multiplexed FIR sequencer: feeds one DSP slice a coefficient/sample pair per cycle
// and closes the accumulation through the slice's PCIN/P path, strobing P out as Y.
module dsp_mac_fir_seq
    import dsp_pkg::*;
#(
    parameter int                   IN_WIDTH  = 18,
    parameter int                   OUT_WIDTH = 48,
    parameter int                   NTAPS     = 5,
    parameter int                   ADDR_W    = 4,
    parameter logic [OUT_WIDTH-1:0] ROUND_C   = '0
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [IN_WIDTH-1:0]  X,
    input  logic                 X_STRB,
    output logic                 X_RDY,
    input  logic                 COEF_WE,
    input  logic [ADDR_W-1:0]    COEF_ADDR,
    input  logic [IN_WIDTH-1:0]  COEF_DATA,
    output logic [IN_WIDTH-1:0]  A,
    output logic [IN_WIDTH-1:0]  B,
    output logic [OUT_WIDTH-1:0] C,
    output logic [OUT_WIDTH-1:0] PCIN,
    output logic                 USE_INREG0,
    output logic                 USE_PCIN,
    input  logic [OUT_WIDTH-1:0] P_IN,
    output logic [OUT_WIDTH-1:0] Y,
    output logic                 Y_STRB
);

    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NTAPS - 1);
    localparam logic [ADDR_W-1:0] NT_A   = ADDR_W'(NTAPS);

    state_t                 r_state, w_state_nxt;
    logic [ADDR_W-1:0]      r_k, w_k_nxt;
    logic [ADDR_W-1:0]      r_wptr, w_wptr_nxt;
    logic                   r_en;
    logic [IN_WIDTH-1:0]    r_a, r_b, w_a_nxt, w_b_nxt;
    logic [ADDR_W-1:0]      w_h_raddr, w_x_raddr;
    logic [IN_WIDTH-1:0]    w_h_rdata, w_x_rdata;
    logic                   w_accept, w_issue;
    tag_t                   w_tag_in;

    // Stage j of the tag pipe lines up with cycle t+1+j of the pair issued in cycle t;
    // r_cap is the final stage (t+4), where P_IN already holds the finished sum.
    logic [SLC_LAT-2:0]     r_vld_pipe;
    tag_t [SLC_LAT-2:0]     r_tag;
    logic                   r_cap;
    logic [OUT_WIDTH-1:0]   r_y;
    logic                   r_y_strb;

    assign w_accept = r_en && (r_state == ST_IDLE) && X_STRB;

    dsp_tap_mem #(
        .IN_WIDTH (IN_WIDTH),
        .NTAPS    (NTAPS),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .i_clk       (CLK),
        .i_rst_n     (RST_N),
        .i_coef_we   (COEF_WE && (r_state == ST_IDLE)),
        .i_coef_addr (COEF_ADDR),
        .i_coef_data (COEF_DATA),
        .i_x_we      (w_accept),
        .i_x_addr    (r_wptr),
        .i_x_data    (X),
        .i_h_raddr   (w_h_raddr),
        .o_h_rdata   (w_h_rdata),
        .i_x_raddr   (w_x_raddr),
        .o_x_rdata   (w_x_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_wptr_nxt  = r_wptr;
        w_h_raddr   = '0;
        w_x_raddr   = r_wptr;
        w_a_nxt     = '0;
        w_b_nxt     = '0;
        w_issue     = 1'b0;
        w_tag_in    = '{tap0: (r_k == '0), last: (r_k == LAST_K)};
        case (r_state)
            ST_IDLE: begin
                // Tap 0 uses the incoming sample directly; it is written to the line this same edge.
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                    w_k_nxt     = '0;
                    w_a_nxt     = w_h_rdata;
                    w_b_nxt     = X;
                end
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                if (r_k == LAST_K) begin
                    w_state_nxt = ST_IDLE;
                    w_wptr_nxt  = (r_wptr == LAST_K) ? '0 : r_wptr + 1'b1;
                end else begin
                    w_k_nxt   = r_k + 1'b1;
                    w_h_raddr = r_k + 1'b1;
                    w_x_raddr = (r_wptr > r_k) ? (r_wptr - r_k - 1'b1)
                                               : (r_wptr + NT_A - r_k - 1'b1);
                    w_a_nxt   = w_h_rdata;
                    w_b_nxt   = w_x_rdata;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_wptr     <= '0;
            r_en       <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_vld_pipe <= '0;
            r_tag      <= '0;
            r_cap      <= 1'b0;
            r_y        <= '0;
            r_y_strb   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_k        <= w_k_nxt;
            r_wptr     <= w_wptr_nxt;
            r_en       <= 1'b1;
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_vld_pipe <= {r_vld_pipe[SLC_LAT-3:0], w_issue};
            r_tag      <= {r_tag[SLC_LAT-3:0], w_tag_in};
            r_cap      <= r_vld_pipe[SLC_LAT-2] && r_tag[SLC_LAT-2].last;
            r_y_strb   <= r_cap;
            if (r_cap)
                r_y <= P_IN;
        end
    end

    assign X_RDY      = r_en && (r_state == ST_IDLE);
    assign A          = r_a;
    assign B          = r_b;
    assign C          = ROUND_C;
    assign PCIN       = P_IN;
    assign USE_INREG0 = 1'b1;
    assign USE_PCIN   = r_vld_pipe[SLC_LAT-2] && !r_tag[SLC_LAT-2].tap0;
    assign Y          = r_y;
    assign Y_STRB     = r_y_strb;

endmodule

// File: tb/tb_dsp_mac_fir_seq.sv
// Bench for dsp_mac_fir_seq: two instances (ROUND_C 0 and 100) each closed through a slice model,
// checked every cycle against a sample-history FIR model plus hand-computed literal results.
module tb_dsp_mac_fir_seq;
    import dsp_pkg::*;

    localparam int IW = 18;
    localparam int OW = 48;
    localparam int N  = 5;
    localparam int AW = 4;
    localparam logic [OW-1:0] RC0 = 48'd0;
    localparam logic [OW-1:0] RC1 = 48'd100;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [IW-1:0] X = '0;
    logic          X_STRB = 1'b0;
    logic          COEF_WE = 1'b0;
    logic [AW-1:0] COEF_ADDR = '0;
    logic [IW-1:0] COEF_DATA = '0;

    logic          x_rdy [2];
    logic [IW-1:0] a [2];
    logic [IW-1:0] b [2];
    logic [OW-1:0] c [2];
    logic [OW-1:0] pcin [2];
    logic [OW-1:0] p [2];
    logic [OW-1:0] y [2];
    logic          use_inreg0 [2];
    logic          use_pcin [2];
    logic          y_strb [2];

    always #5 CLK = ~CLK;

    dsp_mac_fir_seq #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NTAPS(N), .ADDR_W(AW), .ROUND_C(RC0)) u0 (
        .CLK(CLK), .RST_N(RST_N), .X(X), .X_STRB(X_STRB), .X_RDY(x_rdy[0]),
        .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA),
        .A(a[0]), .B(b[0]), .C(c[0]), .PCIN(pcin[0]), .USE_INREG0(use_inreg0[0]),
        .USE_PCIN(use_pcin[0]), .P_IN(p[0]), .Y(y[0]), .Y_STRB(y_strb[0]));

    dsp_mac_fir_seq #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .NTAPS(N), .ADDR_W(AW), .ROUND_C(RC1)) u1 (
        .CLK(CLK), .RST_N(RST_N), .X(X), .X_STRB(X_STRB), .X_RDY(x_rdy[1]),
        .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA),
        .A(a[1]), .B(b[1]), .C(c[1]), .PCIN(pcin[1]), .USE_INREG0(use_inreg0[1]),
        .USE_PCIN(use_pcin[1]), .P_IN(p[1]), .Y(y[1]), .Y_STRB(y_strb[1]));

    // Slice stand-in: pair in t -> m at end of t+2 -> P at end of t+3.
    function automatic logic [OW-1:0] slc_prod(input logic [IW-1:0] av, input logic [IW-1:0] bv);
        longint sa, ub;
        sa = longint'($signed(av)) >>> SLC_TRUNC;
        ub = longint'(bv >> SLC_TRUNC);
        return OW'((sa * ub) <<< SLC_SHIFT);
    endfunction

    logic [OW-1:0] s_p0 [2];
    logic [OW-1:0] s_p1 [2];
    logic [OW-1:0] s_m [2];

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 2; i++) begin
                s_p0[i] <= '0; s_p1[i] <= '0; s_m[i] <= '0; p[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                s_p0[i] <= slc_prod(a[i], b[i]);
                s_p1[i] <= s_p0[i];
                s_m[i]  <= s_p1[i];
                p[i]    <= use_pcin[i] ? s_m[i] + pcin[i] : s_m[i] + c[i];
            end
        end
    end

    // Reference FIR: coefficient array, newest-first sample history, scheduled results.
    typedef struct { int due; longint yv; } ev_t;
    int                   cyc = 0;
    logic signed [IW-1:0] m_h [N];
    logic [IW-1:0]        m_x [N];
    int                   m_busy = 0;
    bit                   m_en = 1'b0;
    int                   m_acc = 0;
    ev_t                  m_q [$];
    int                   acc_cyc [$];

    function automatic longint fir(input logic [IW-1:0] xn);
        longint s;
        logic [IW-1:0] xv;
        s = 0;
        for (int k = 0; k < N; k++) begin
            xv = (k == 0) ? xn : m_x[k-1];
            s += (longint'(m_h[k]) >>> 4) * longint'(xv >> 4) * 256;
        end
        return s;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < N; k++) begin
                m_h[k] <= '0; m_x[k] <= '0;
            end
            m_busy <= 0;
            m_en   <= 1'b0;
            m_q.delete();
        end else begin
            m_en <= 1'b1;
            if (m_q.size() > 0 && m_q[0].due == cyc) void'(m_q.pop_front());
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
            end else if (m_en && X_STRB) begin
                m_q.push_back('{cyc + N + 5, fir(X)});
                acc_cyc.push_back(cyc);
                m_acc  <= m_acc + 1;
                m_busy <= N;
                for (int k = 1; k < N; k++) m_x[k] <= m_x[k-1];
                m_x[0] <= X;
            end
            if (m_busy == 0 && COEF_WE && int'(COEF_ADDR) < N) m_h[int'(COEF_ADDR)] <= COEF_DATA;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] cap0 [$];
    logic [OW-1:0] cap1 [$];
    int strb_cyc [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic          es;
        logic [OW-1:0] ey;
        for (int i = 0; i < 2; i++) begin
            if (!RST_N) begin
                chk("rst_x_rdy", x_rdy[i], 0);
                chk("rst_a", a[i], 0);
                chk("rst_b", b[i], 0);
                chk("rst_use_pcin", use_pcin[i], 0);
                chk("rst_y", y[i], 0);
                chk("rst_y_strb", y_strb[i], 0);
            end else begin
                es = (m_q.size() > 0) && (m_q[0].due == cyc);
                chk("x_rdy", x_rdy[i], (m_en && m_busy == 0) ? 1 : 0);
                chk("y_strb", y_strb[i], es);
                if (es) begin
                    ey = OW'(m_q[0].yv) + ((i == 0) ? RC0 : RC1);
                    chk("y", y[i], ey);
                end
                if (y_strb[i]) begin
                    if (i == 0) begin
                        cap0.push_back(y[i]);
                        strb_cyc.push_back(cyc);
                    end else begin
                        cap1.push_back(y[i]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [IW-1:0] v);
        int n0, w;
        n0 = m_acc; X = v; X_STRB = 1'b1; w = 0;
        while (m_acc == n0 && w < 50) begin tick(); w++; end
        X_STRB = 1'b0;
        chk("send_accepted", (m_acc != n0) ? 1 : 0, 1);
    endtask

    task automatic wcoef_now(input int k, input logic [IW-1:0] v);
        COEF_WE = 1'b1; COEF_ADDR = AW'(k); COEF_DATA = v;
        tick();
        COEF_WE = 1'b0;
    endtask

    task automatic wcoef(input int k, input logic [IW-1:0] v);
        int w;
        w = 0;
        while (m_busy != 0 && w < 50) begin tick(); w++; end
        wcoef_now(k, v);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (m_q.size() > 0 && w < 100) begin tick(); w++; end
        chk("drain_done", m_q.size(), 0);
        tick(); tick();
    endtask

    task automatic load_ramp();
        for (int k = 0; k < N; k++) wcoef(k, IW'(256 * (k + 1)));
    endtask

    task automatic clr();
        cap0.delete(); cap1.delete(); strb_cyc.delete();
    endtask

    initial begin
        int base, n0;
        logic [OW-1:0] imp [5];
        logic [OW-1:0] stp [6];
        imp = '{48'd4096, 48'd8192, 48'd12288, 48'd16384, 48'd20480};
        stp = '{48'd4096, 48'd12288, 48'd24576, 48'd40960, 48'd61440, 48'd61440};

        tick(); tick();
        RST_N = 1'b1;
        tick();
        chk("rdy_after_rst", x_rdy[0], 1);

        load_ramp();

        clr(); base = acc_cyc.size();
        send(16); for (int i = 0; i < 4; i++) send(0);
        drain();
        chk("imp_count", cap0.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("imp_y0", cap0[i], imp[i]);
            chk("imp_y1", cap1[i], imp[i] + 48'd100);
            chk("imp_latency", strb_cyc[i] - acc_cyc[base + i], 10);
        end

        clr();
        for (int i = 0; i < 6; i++) send(16);
        drain();
        chk("step_count", cap0.size(), 6);
        for (int i = 0; i < 6; i++) chk("step_y0", cap0[i], stp[i]);

        clr(); n0 = m_acc;
        X = 16; X_STRB = 1'b1;
        repeat (30) tick();
        X_STRB = 1'b0;
        drain();
        chk("hs_accepts", m_acc - n0, 5);
        chk("hs_strobes", cap0.size(), 5);
        chk("hs_y0", cap0[4], 48'd61440);

        clr();
        send(16);
        tick(); tick();
        RST_N = 1'b0;
        #1;
        chk("midrst_a", a[0], 0);
        chk("midrst_b", b[0], 0);
        chk("midrst_rdy", x_rdy[0], 0);
        tick(); tick();
        RST_N = 1'b1;
        repeat (15) tick();
        chk("midrst_no_strb", cap0.size() + cap1.size(), 0);

        load_ramp();
        clr();
        send(16);
        wcoef_now(0, 18'd4096);
        send(16);
        wcoef(0, 18'd4096);
        send(16);
        drain();
        chk("cw_count", cap0.size(), 3);
        chk("cw_first", cap0[0], 48'd4096);
        chk("cw_ignored", cap0[1], 48'd12288);
        chk("cw_honoured", cap0[2], 48'd86016);

        clr();
        wcoef(0, 18'h3FF00);
        for (int k = 1; k < N; k++) wcoef(k, 18'd0);
        send(32);
        drain();
        chk("neg_y0", cap0[0], 48'hFFFF_FFFF_E000);
        chk("neg_y1", cap1[0], 48'hFFFF_FFFF_E064);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
